// File: rtl/mu0_mem_responder_pkg.sv
// Shared types and constants for the MU0 memory responder.
// The I/O window constants only matter when MU0_MEM_IO_EN is defined.
package mu0_mem_pkg;

    localparam int MU0_DATA_W = 16;
    localparam int MU0_ADDR_W = 12;

    localparam logic [MU0_ADDR_W-1:0] MU0_IO_BASE = 12'hFF0;
    localparam logic [MU0_ADDR_W-1:0] MU0_IO_OUT  = 12'hFF0;
    localparam logic [MU0_ADDR_W-1:0] MU0_IO_IN   = 12'hFF1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mu0_state_e;

    // The window runs from the base up to the very top of the address space.
    function automatic logic mu0_in_io_window(input logic [MU0_ADDR_W-1:0] a);
        return a >= MU0_IO_BASE;
    endfunction

endpackage

// File: rtl/mu0_mem_responder_if.sv
// Four-phase req/ack bus between the MU0 datapath and the memory responder.
interface mu0_mem_responder_if
    import mu0_mem_pkg::*;
;
    logic                  req;
    logic                  rnw;
    logic [MU0_ADDR_W-1:0] addr;
    logic [MU0_DATA_W-1:0] wdata;
    logic                  ack;
    logic [MU0_DATA_W-1:0] rdata;

    modport master (
        output req, rnw, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, rnw, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mu0_mem_responder_ram4k16.sv
// Behavioural single-port 4096 x 16 synchronous RAM with a registered read port.
module mu0_ram4k16
    import mu0_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [MU0_ADDR_W-1:0] addr,
    input  logic [MU0_DATA_W-1:0] wdata,
    output logic [MU0_DATA_W-1:0] rdata
);

    logic [MU0_DATA_W-1:0] mem_q [1 << MU0_ADDR_W];

    // Read-first: a write edge returns the old word, which the responder never uses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/mu0_mem_responder.sv
// MU0 memory responder: req/ack handshake with WAIT wait states over a 4K x 16 RAM.
// Define MU0_MEM_IO_EN to map an I/O window at 0xFF0..0xFFF.
module mu0_mem_responder #(
    parameter int WAIT = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    mu0_mem_responder_if.slave                bus,
    input  logic [mu0_mem_pkg::MU0_DATA_W-1:0] io_in,
    output logic [mu0_mem_pkg::MU0_DATA_W-1:0] io_out
);
    import mu0_mem_pkg::*;

    localparam logic [3:0] WaitCnt = 4'(WAIT);

    mu0_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rnw_q, rnw_d;
    logic [MU0_ADDR_W-1:0] addr_q, addr_d;
    logic [MU0_DATA_W-1:0] wdata_q, wdata_d;
    logic [MU0_DATA_W-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;

    logic                  ram_we_d;
    logic                  ram_we;
    logic [MU0_ADDR_W-1:0] ram_addr;
    logic [MU0_DATA_W-1:0] ram_rdata;
    logic [MU0_DATA_W-1:0] read_value;
    logic                  in_window;

`ifdef MU0_MEM_IO_EN
    logic [MU0_DATA_W-1:0] io_out_q, io_out_d;
    logic [MU0_DATA_W-1:0] io_sync1_q, io_sync2_q;

    assign in_window = mu0_in_io_window(addr_q);
    assign io_out    = io_out_q;

    always_comb begin
        read_value = ram_rdata;
        if (in_window) begin
            if (addr_q == MU0_IO_OUT) begin
                read_value = io_out_q;
            end else if (addr_q == MU0_IO_IN) begin
                read_value = io_sync2_q;
            end else begin
                read_value = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_sync1_q <= '0;
            io_sync2_q <= '0;
            io_out_q   <= '0;
        end else begin
            io_sync1_q <= io_in;
            io_sync2_q <= io_sync1_q;
            io_out_q   <= io_out_d;
        end
    end
`else
    logic unused_io_in;

    assign in_window    = 1'b0;
    assign read_value   = ram_rdata;
    assign io_out       = '0;
    assign unused_io_in = ^io_in;
`endif

    // The RAM reads the live address in IDLE so its registered output already
    // holds the captured word by the time the access edge comes round.
    assign ram_addr = (state_q == IDLE) ? bus.addr : addr_q;
    assign ram_we   = ram_we_d & ~reset;

    mu0_ram4k16 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = ack_q;
        ram_we_d = 1'b0;
`ifdef MU0_MEM_IO_EN
        io_out_d = io_out_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    rnw_d   = bus.rnw;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = WaitCnt;
                    state_d = mu0_mem_pkg::WAIT;
                end
            end
            mu0_mem_pkg::WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                    if (rnw_q) begin
                        rdata_d = read_value;
                    end else if (!in_window) begin
                        ram_we_d = 1'b1;
                    end
`ifdef MU0_MEM_IO_EN
                    if (!rnw_q && addr_q == MU0_IO_OUT) begin
                        io_out_d = wdata_q;
                    end
`endif
                end
            end
            DONE: begin
                if (!bus.req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Directed bench for mu0_mem_responder: one instance with WAIT=0, one with WAIT=3.
// I/O window checks follow MU0_MEM_IO_EN.
module tb_mu0_mem_responder;

    logic        clk;
    logic        reset0;
    logic        reset3;
    logic [15:0] io_in;
    logic [15:0] io_out0;
    logic [15:0] io_out3;

    int assertCount = 0;
    int failCount   = 0;

`ifdef MU0_MEM_IO_EN
    localparam logic [11:0] WsAddr = 12'hEFF;
`else
    localparam logic [11:0] WsAddr = 12'hFFF;
`endif

    mu0_mem_responder_if bus0 ();
    mu0_mem_responder_if bus3 ();

    mu0_mem_responder #(.WAIT(0)) dut0 (
        .clk    (clk),
        .reset  (reset0),
        .bus    (bus0),
        .io_in  (io_in),
        .io_out (io_out0)
    );

    mu0_mem_responder #(.WAIT(3)) dut3 (
        .clk    (clk),
        .reset  (reset3),
        .bus    (bus3),
        .io_in  (io_in),
        .io_out (io_out3)
    );

    always #5 clk = ~clk;

    task automatic setBus(input int sel, input logic rq, input logic r,
                          input logic [11:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus0.req = rq; bus0.rnw = r; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus3.req = rq; bus3.rnw = r; bus3.addr = a; bus3.wdata = d;
        end
    endtask

    function automatic logic getAck(input int sel);
        return (sel == 0) ? bus0.ack : bus3.ack;
    endfunction

    function automatic logic [15:0] getRdata(input int sel);
        return (sel == 0) ? bus0.rdata : bus3.rdata;
    endfunction

    // Full handshake; edges counted from the request being raised (edge 1 = capture).
    task automatic doAccess(input int sel, input logic r, input logic [11:0] a,
                            input logic [15:0] d, output int riseEdges,
                            output int fallEdges, output logic [15:0] rd);
        @(negedge clk);
        setBus(sel, 1'b1, r, a, d);
        riseEdges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (getAck(sel)) begin
                riseEdges = i;
                break;
            end
        end
        rd = getRdata(sel);
        setBus(sel, 1'b0, r, a, d);
        fallEdges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!getAck(sel)) begin
                fallEdges = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset0 = 1'b1;
        reset3 = 1'b1;
        repeat (3) @(negedge clk);
        assertCount++;
        if (bus0.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_ack0: got %b expected 0", bus0.ack);
        end
        assertCount++;
        if (bus0.rdata !== 16'h0000) begin
            failCount++; $display("[TB] FAIL reset_rdata0: got %h expected 0000", bus0.rdata);
        end
        assertCount++;
        if (io_out0 !== 16'h0000) begin
            failCount++; $display("[TB] FAIL reset_io_out0: got %h expected 0000", io_out0);
        end
        assertCount++;
        if (bus3.ack !== 1'b0 || bus3.rdata !== 16'h0000) begin
            failCount++; $display("[TB] FAIL reset_dut3: got ack %b rdata %h expected 0 0000", bus3.ack, bus3.rdata);
        end
        reset0 = 1'b0;
        reset3 = 1'b0;
    endtask

    task automatic test_write_read;
        int rise, fall;
        logic [15:0] rd;
        doAccess(0, 1'b0, 12'h005, 16'h1234, rise, fall, rd);
        assertCount++;
        if (rise !== 2 || fall !== 1) begin
            failCount++; $display("[TB] FAIL wr_latency: got rise %0d fall %0d expected 2 1", rise, fall);
        end
        doAccess(0, 1'b1, 12'h005, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rise !== 2 || rd !== 16'h1234) begin
            failCount++; $display("[TB] FAIL rd_005: got rise %0d data %h expected 2 1234", rise, rd);
        end
        doAccess(0, 1'b0, 12'h006, 16'hABCD, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h1234) begin
            failCount++; $display("[TB] FAIL wr_holds_rdata: got %h expected 1234", rd);
        end
        doAccess(0, 1'b0, 12'h000, 16'h0F0F, rise, fall, rd);
        doAccess(0, 1'b1, 12'h000, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h0F0F) begin
            failCount++; $display("[TB] FAIL rd_000: got %h expected 0f0f", rd);
        end
        doAccess(0, 1'b1, 12'h006, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'hABCD) begin
            failCount++; $display("[TB] FAIL rd_006: got %h expected abcd", rd);
        end
    endtask

    task automatic test_wait_states;
        int rise, fall;
        logic [15:0] rd;
        logic badAck;
        doAccess(3, 1'b0, 12'h000, 16'h1111, rise, fall, rd);
        doAccess(3, 1'b0, WsAddr, 16'hBEEF, rise, fall, rd);
        assertCount++;
        if (rise !== 5 || fall !== 1) begin
            failCount++; $display("[TB] FAIL wait3_wr_latency: got rise %0d fall %0d expected 5 1", rise, fall);
        end
        // Address moves to 0x000 right after capture; the captured address must win.
        @(negedge clk);
        setBus(3, 1'b1, 1'b1, WsAddr, 16'h0000);
        @(negedge clk);
        setBus(3, 1'b1, 1'b1, 12'h000, 16'h0000);
        rise = -1;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (bus3.ack) begin
                rise = i;
                break;
            end
        end
        assertCount++;
        if (rise !== 5 || bus3.rdata !== 16'hBEEF) begin
            failCount++; $display("[TB] FAIL wait3_rd: got rise %0d data %h expected 5 beef", rise, bus3.rdata);
        end
        setBus(3, 1'b0, 1'b1, 12'h000, 16'h0000);
        repeat (2) @(negedge clk);
        // Request dropped during WAIT: the access completes and ack pulses once.
        setBus(3, 1'b1, 1'b1, 12'h000, 16'h0000);
        @(negedge clk);
        setBus(3, 1'b0, 1'b1, 12'h000, 16'h0000);
        badAck = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            if (bus3.ack !== 1'b0) badAck = 1'b1;
        end
        assertCount++;
        if (badAck !== 1'b0) begin
            failCount++; $display("[TB] FAIL early_ack: got early ack expected none");
        end
        @(negedge clk);
        assertCount++;
        if (bus3.ack !== 1'b1 || bus3.rdata !== 16'h1111) begin
            failCount++; $display("[TB] FAIL pulse_high: got ack %b data %h expected 1 1111", bus3.ack, bus3.rdata);
        end
        @(negedge clk);
        assertCount++;
        if (bus3.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL pulse_low: got %b expected 0", bus3.ack);
        end
    endtask

    task automatic test_reset_abort;
        int rise, fall;
        logic [15:0] rd;
        doAccess(3, 1'b0, 12'h010, 16'h5555, rise, fall, rd);
        @(negedge clk);
        setBus(3, 1'b1, 1'b0, 12'h010, 16'hAAAA);
        @(negedge clk);
        reset3 = 1'b1;
        @(negedge clk);
        assertCount++;
        if (bus3.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL abort_ack_a: got %b expected 0", bus3.ack);
        end
        @(negedge clk);
        assertCount++;
        if (bus3.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL abort_ack_b: got %b expected 0", bus3.ack);
        end
        setBus(3, 1'b0, 1'b0, 12'h010, 16'hAAAA);
        reset3 = 1'b0;
        doAccess(3, 1'b1, 12'h010, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h5555) begin
            failCount++; $display("[TB] FAIL abort_mem: got %h expected 5555", rd);
        end
        // Reset landing exactly on the access edge must also suppress the write.
        doAccess(0, 1'b0, 12'h020, 16'h2222, rise, fall, rd);
        @(negedge clk);
        setBus(0, 1'b1, 1'b0, 12'h020, 16'h9999);
        @(negedge clk);
        reset0 = 1'b1;
        @(negedge clk);
        assertCount++;
        if (bus0.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL coincide_ack: got %b expected 0", bus0.ack);
        end
        reset0 = 1'b0;
        setBus(0, 1'b0, 1'b0, 12'h020, 16'h9999);
        doAccess(0, 1'b1, 12'h020, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h2222) begin
            failCount++; $display("[TB] FAIL coincide_mem: got %h expected 2222", rd);
        end
    endtask

    task automatic test_io;
        int rise, fall;
        logic [15:0] rd;
        doAccess(0, 1'b0, 12'hFF0, 16'h00FF, rise, fall, rd);
`ifdef MU0_MEM_IO_EN
        assertCount++;
        if (io_out0 !== 16'h00FF) begin
            failCount++; $display("[TB] FAIL io_out: got %h expected 00ff", io_out0);
        end
        doAccess(0, 1'b1, 12'hFF0, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h00FF) begin
            failCount++; $display("[TB] FAIL io_out_rd: got %h expected 00ff", rd);
        end
        @(negedge clk);
        io_in = 16'hC3C3;
        repeat (3) @(negedge clk);
        doAccess(0, 1'b1, 12'hFF1, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'hC3C3) begin
            failCount++; $display("[TB] FAIL io_in_rd: got %h expected c3c3", rd);
        end
        doAccess(0, 1'b0, 12'hFF7, 16'h1234, rise, fall, rd);
        doAccess(0, 1'b1, 12'hFF7, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h0000 || io_out0 !== 16'h00FF) begin
            failCount++; $display("[TB] FAIL io_hole: got data %h io_out %h expected 0000 00ff", rd, io_out0);
        end
`else
        assertCount++;
        if (io_out0 !== 16'h0000) begin
            failCount++; $display("[TB] FAIL io_out_tied: got %h expected 0000", io_out0);
        end
        doAccess(0, 1'b1, 12'hFF0, 16'h0000, rise, fall, rd);
        assertCount++;
        if (rd !== 16'h00FF) begin
            failCount++; $display("[TB] FAIL ram_ff0: got %h expected 00ff", rd);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int rise, fall;
        logic dropped;
        @(negedge clk);
        setBus(0, 1'b1, 1'b1, 12'h005, 16'h0000);
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus0.ack) begin
                rise = i;
                break;
            end
        end
        assertCount++;
        if (rise !== 2 || bus0.rdata !== 16'h1234) begin
            failCount++; $display("[TB] FAIL hold_first: got rise %0d data %h expected 2 1234", rise, bus0.rdata);
        end
        // Turn the held request into a write; it must not be performed.
        setBus(0, 1'b1, 1'b0, 12'h005, 16'hDEAD);
        dropped = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus0.ack !== 1'b1) dropped = 1'b1;
        end
        assertCount++;
        if (dropped !== 1'b0) begin
            failCount++; $display("[TB] FAIL hold_ack: got ack dropped expected held high");
        end
        setBus(0, 1'b0, 1'b1, 12'h005, 16'h0000);
        @(negedge clk);
        assertCount++;
        if (bus0.ack !== 1'b0) begin
            failCount++; $display("[TB] FAIL hold_release: got %b expected 0", bus0.ack);
        end
        setBus(0, 1'b1, 1'b1, 12'h005, 16'h0000);
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus0.ack) begin
                rise = i;
                break;
            end
        end
        assertCount++;
        if (rise !== 2 || bus0.rdata !== 16'h1234) begin
            failCount++; $display("[TB] FAIL b2b_second: got rise %0d data %h expected 2 1234", rise, bus0.rdata);
        end
        setBus(0, 1'b0, 1'b1, 12'h005, 16'h0000);
        fall = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus0.ack) begin
                fall = i;
                break;
            end
        end
        assertCount++;
        if (fall !== 1) begin
            failCount++; $display("[TB] FAIL b2b_release: got %0d expected 1", fall);
        end
    endtask

    initial begin
        clk    = 1'b0;
        reset0 = 1'b1;
        reset3 = 1'b1;
        io_in  = 16'h0000;
        setBus(0, 1'b0, 1'b0, 12'h000, 16'h0000);
        setBus(3, 1'b0, 1'b0, 12'h000, 16'h0000);
        $display("[TB] starting mu0_mem_responder bench");
        test_reset;
        test_write_read;
        test_wait_states;
        test_reset_abort;
        test_io;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/mu0_mem_responder.md
# mu0_mem_responder

Memory-side responder for the MU0 12-bit address bus: it accepts read/write requests from the processor's address/data path and completes them against a 4096 x 16 word store using a four-phase req/ack handshake with a programmable number of wait states. It sits downstream of the MU0 address multiplexer, whose 12-bit output drives `addr`. It optionally decodes a small memory-mapped I/O window at the top of the address space.

## Interface
- `WAIT`, default 0: wait-state count, legal range 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; held high by the initiator until `ack` is seen.
- `rnw`  in  1  1 = read, 0 = write; sampled with `req`.
- `addr`  in  12  word address; sampled with `req`.
- `wdata`  in  16  write data; sampled with `req`.
- `ack`  out  1  access complete; held high until `req` falls.
- `rdata`  out  16  read data; valid while `ack` is high after a read.
- `io_in`  in  16  external input port; used only with the I/O window compiled in.
- `io_out`  out  16  external output register; driven only with the I/O window compiled in.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: when `req`=1, capture `rnw`, `addr` and `wdata`; load counter = `WAIT`; go to WAIT. `req`=0 leaves the state at IDLE.
- WAIT, counter != 0: decrement the counter and stay in WAIT. Input changes are ignored because the access uses the captured values.
- WAIT, counter = 0: perform the access on the captured values, set `ack`=1, go to DONE.
  - Read: `rdata` <= mem[addr].
  - Write: mem[addr] <= wdata; `rdata` holds its previous value.
- DONE: `ack` stays 1 while `req`=1. When `req`=0: `ack`<=0, go to IDLE.
- Back-to-back accesses: a new request is accepted only from IDLE, so `req` must be low for at least one sampled edge between accesses.
- Memory contents are not cleared by `reset` and are undefined until written.

## Timing
- Reset values: state IDLE, `ack`=0, `rdata`=0x0000, `io_out`=0x0000, counter=0.
- Latency: `ack` rises on the edge (WAIT+1) edges after the capture edge. With `WAIT`=0 this is the next edge.
- Release: `ack` falls on the first edge at which `req` is sampled low in DONE.
- Reset in the middle of an access: if it arrives in WAIT before the access edge, the write is aborted and memory is unchanged. If it coincides with the access edge, reset wins and no write is performed. `ack` returns to 0 in either case.
- Address wrap: none. All 4096 addresses are valid; addresses 0x000 and 0xFFF are ordinary words unless the I/O window is enabled.
- If `req` falls during WAIT, the access still completes. `ack` then pulses for exactly one cycle, because DONE sees `req`=0 on the next edge.

## Configuration
- Macro: `MU0_MEM_IO_EN`.
- Defined: addresses 0xFF0..0xFFF form an I/O window and no RAM is accessed there.
  - Write to 0xFF0: `io_out` <= wdata.
  - Read of 0xFF0: returns `io_out`.
  - Read of 0xFF1: returns `io_in` through a two-flop synchronizer, so the value returned is the one sampled two edges earlier.
  - Other window addresses: reads return 0x0000 and writes are ignored.
  - Synchronizer flops reset to 0.
- Undefined: the whole space is RAM, `io_out` is tied to 0x0000 and `io_in` is unused.

## Structure
- Package `mu0_mem_pkg` holds:
  - the state enum (IDLE, WAIT, DONE);
  - `MU0_IO_BASE` = 12'hFF0;
  - `MU0_IO_OUT` = 12'hFF0;
  - `MU0_IO_IN` = 12'hFF1;
  - `MU0_DATA_W` = 16;
  - `MU0_ADDR_W` = 12.
- Sub-module `mu0_ram4k16`: a behavioural single-port synchronous 4096 x 16 array with `clk`, `we`, `addr`, `wdata` and registered `rdata`. The responder owns the FSM, the wait counter and the I/O decode.

## Test plan
- Reset with `WAIT`=0: `ack`=0, `rdata`=0x0000, `io_out`=0x0000.
- Write then read, `WAIT`=0:
  - Write 0x1234 to 0x005: `ack` rises 1 edge after capture, falls the edge after `req` drops.
  - Read 0x005: `rdata`=0x1234.
- `WAIT`=3 read of 0xFFF after writing 0xBEEF there, macro undefined: `ack` rises 4 edges after capture, `rdata`=0xBEEF. Changing `addr` to 0x000 during WAIT has no effect on the result.
- Reset asserted in WAIT during a write of 0xAAAA to 0x010, which previously held 0x5555: `ack` stays 0 and a later read of 0x010 returns 0x5555.
- With `MU0_MEM_IO_EN` defined:
  - Write 0x00FF to 0xFF0: `io_out`=0x00FF.
  - Drive `io_in`=0xC3C3 for 3+ cycles, then read 0xFF1: `rdata`=0xC3C3.
  - Read 0xFF7: `rdata`=0x0000.
- `req` held high across DONE: `ack` stays 1 and no second access occurs. After `req` drops for one edge, a new request is accepted.
